// File: rtl/vector_alu_sequencer_pkg.sv
// Shared definitions for the vector ALU sequencer: FSM states, lane count and the
// ALU op / operand-type encodings shared with the per-lane VECTOR_ALU.
package vector_alu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_t;

  localparam int unsigned SEQ_LANE_INDEX_SIZE = 1;
  localparam int unsigned SEQ_LANES           = 1 << SEQ_LANE_INDEX_SIZE;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    OPND_VV   = 2'd0,
    OPND_VX   = 2'd1,
    OPND_VI   = 2'd2,
    OPND_RSVD = 2'd3
  } vec_operand_t;

  function automatic int unsigned lanes_of(input int unsigned lane_index_size);
    return 1 << lane_index_size;
  endfunction

endpackage

// File: rtl/vector_alu_sequencer_wb_stage.sv
// vseq_wb_stage: one-beat registered write-back stage (wb_en/wb_base/wb_data) that
// freezes its contents while hold is high and suppresses wb_en meanwhile.
module vseq_wb_stage
  import vector_alu_sequencer_pkg::*;
#(
  parameter int LANES = SEQ_LANES,
  parameter int LEN   = 32,
  parameter int IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold,
  input  logic [LANES-1:0]       lane_en,
  input  logic [IDX_W-1:0]       elem_base,
  input  logic [LANES*LEN-1:0]   lane_result,
  output logic [LANES-1:0]       wb_en,
  output logic [IDX_W-1:0]       wb_base,
  output logic [LANES*LEN-1:0]   wb_data
);

  logic [LANES-1:0] wb_en_reg;
  logic [IDX_W-1:0] wb_base_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en_reg   <= '0;
      wb_base_reg <= '0;
    end else if (!hold) begin
      wb_en_reg   <= lane_en;
      wb_base_reg <= elem_base;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_data
    logic [LEN-1:0] data_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_reg <= '0;
      end else if (!hold) begin
        data_reg <= lane_result[gi*LEN +: LEN];
      end
    end

    assign wb_data[gi*LEN +: LEN] = data_reg;
  end

  // The held beat stays registered but must not write until the hold lifts.
  assign wb_en   = wb_en_reg & {LANES{~hold}};
  assign wb_base = wb_base_reg;

endmodule

// File: rtl/vector_alu_sequencer.sv
// Walks the element groups of one vector instruction across the lanes and drives the
// VRF write-back. Optional VECTOR_SEQ_STALL_EN adds a stall input that freezes the beat.
module vector_alu_sequencer
  import vector_alu_sequencer_pkg::*;
#(
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int LANE_INDEX_SIZE  = SEQ_LANE_INDEX_SIZE
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
`ifdef VECTOR_SEQ_STALL_EN
  input  logic                                         stall,
`endif
  input  logic                                         start,
  output logic                                         ready,
  input  logic [ENTRY_INDEX_SIZE:0]                    vl,
  input  logic                                         vm,
  input  logic [VECTOR_SIZE-1:0]                       mask_bits,
  input  logic [2:0]                                   alu_signal_in,
  input  logic [1:0]                                   vec_operand_type_in,
  input  logic [5:0]                                   opcode_in,
  output logic [2:0]                                   alu_signal,
  output logic [1:0]                                   vec_operand_type,
  output logic [5:0]                                   opcode,
  output logic [(1<<LANE_INDEX_SIZE)-1:0]              lane_en,
  output logic [ENTRY_INDEX_SIZE-1:0]                  elem_base,
  input  logic [(1<<LANE_INDEX_SIZE)*LEN-1:0]          lane_result,
  output logic [(1<<LANE_INDEX_SIZE)-1:0]              wb_en,
  output logic [ENTRY_INDEX_SIZE-1:0]                  wb_base,
  output logic [(1<<LANE_INDEX_SIZE)*LEN-1:0]          wb_data,
  output logic                                         done
);

  localparam int LANES = lanes_of(LANE_INDEX_SIZE);
  localparam int IW    = ENTRY_INDEX_SIZE + 1;

  seq_state_t             state_reg;
  logic [IW-1:0]          vl_eff_reg;
  logic [IW-1:0]          group_reg;
  logic                   vm_reg;
  logic [VECTOR_SIZE-1:0] mask_reg;
  logic [LANES-1:0]       lane_en_reg;
  logic                   done_reg;
  logic                   ready_reg;
  logic [2:0]             alu_signal_reg;
  logic [1:0]             vec_operand_type_reg;
  logic [5:0]             opcode_reg;

  logic                   stall_active;
  logic [IW-1:0]          vl_clamped;
  logic [IW-1:0]          base_cur;
  logic [IW-1:0]          base_next;
  logic                   last_group;
  logic [LANES-1:0]       first_en;
  logic [LANES-1:0]       next_en;

`ifdef VECTOR_SEQ_STALL_EN
  assign stall_active = stall & (state_reg != ST_IDLE);
`else
  assign stall_active = 1'b0;
`endif

  assign vl_clamped = (vl > IW'(VECTOR_SIZE)) ? IW'(VECTOR_SIZE) : vl;
  assign base_cur   = group_reg << LANE_INDEX_SIZE;
  assign base_next  = (group_reg + IW'(1)) << LANE_INDEX_SIZE;
  // IW-bit sum cannot wrap: base < VECTOR_SIZE and LANES <= VECTOR_SIZE.
  assign last_group = (base_cur + IW'(LANES)) >= vl_eff_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IW-1:0] first_idx;
    logic [IW-1:0] next_idx;

    assign first_idx    = IW'(gi);
    assign next_idx     = base_next + IW'(gi);
    assign first_en[gi] = (first_idx < vl_clamped) &
                          (vm | mask_bits[first_idx[ENTRY_INDEX_SIZE-1:0]]);
    assign next_en[gi]  = (next_idx < vl_eff_reg) &
                          (vm_reg | mask_reg[next_idx[ENTRY_INDEX_SIZE-1:0]]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg            <= ST_IDLE;
      vl_eff_reg           <= '0;
      group_reg            <= '0;
      vm_reg               <= 1'b0;
      mask_reg             <= '0;
      lane_en_reg          <= '0;
      done_reg             <= 1'b0;
      ready_reg            <= 1'b1;
      alu_signal_reg       <= '0;
      vec_operand_type_reg <= '0;
      opcode_reg           <= '0;
    end else if (!stall_active) begin
      case (state_reg)
        ST_IDLE: begin
          if (start && ready_reg) begin
            vl_eff_reg           <= vl_clamped;
            vm_reg               <= vm;
            mask_reg             <= mask_bits;
            alu_signal_reg       <= alu_signal_in;
            vec_operand_type_reg <= vec_operand_type_in;
            opcode_reg           <= opcode_in;
            group_reg            <= '0;
            ready_reg            <= 1'b0;
            if (vl_clamped != '0) begin
              state_reg   <= ST_ISSUE;
              lane_en_reg <= first_en;
            end else begin
              state_reg <= ST_FLUSH;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (last_group) begin
            state_reg   <= ST_FLUSH;
            lane_en_reg <= '0;
            done_reg    <= 1'b1;
          end else begin
            group_reg   <= group_reg + IW'(1);
            lane_en_reg <= next_en;
          end
        end
        ST_FLUSH: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg   <= ST_IDLE;
          lane_en_reg <= '0;
          done_reg    <= 1'b0;
          ready_reg   <= 1'b1;
        end
      endcase
    end
  end

  vseq_wb_stage #(
    .LANES (LANES),
    .LEN   (LEN),
    .IDX_W (ENTRY_INDEX_SIZE)
  ) u_wb_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (stall_active),
    .lane_en     (lane_en_reg),
    .elem_base   (base_cur[ENTRY_INDEX_SIZE-1:0]),
    .lane_result (lane_result),
    .wb_en       (wb_en),
    .wb_base     (wb_base),
    .wb_data     (wb_data)
  );

  assign ready            = ready_reg;
  assign done             = done_reg & ~stall_active;
  assign lane_en          = lane_en_reg & {LANES{~stall_active}};
  assign elem_base        = base_cur[ENTRY_INDEX_SIZE-1:0];
  assign alu_signal       = alu_signal_reg;
  assign vec_operand_type = vec_operand_type_reg;
  assign opcode           = opcode_reg;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Randomized self-checking bench for vector_alu_sequencer against a beat-list model;
// exercises stall behaviour when built with VECTOR_SEQ_STALL_EN.
module tb_vector_alu_sequencer;

  localparam int LANES = 2;
  localparam int VSIZE = 8;
`ifdef VECTOR_SEQ_STALL_EN
  localparam int STALL_ON = 1;
`else
  localparam int STALL_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        start;
  logic        ready;
  logic [3:0]  vl;
  logic        vm;
  logic [7:0]  mask_bits;
  logic [2:0]  alu_signal_in;
  logic [1:0]  vec_operand_type_in;
  logic [5:0]  opcode_in;
  logic [2:0]  alu_signal;
  logic [1:0]  vec_operand_type;
  logic [5:0]  opcode;
  logic [1:0]  lane_en;
  logic [2:0]  elem_base;
  logic [63:0] lane_result;
  logic [1:0]  wb_en;
  logic [2:0]  wb_base;
  logic [63:0] wb_data;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vector_alu_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
`ifdef VECTOR_SEQ_STALL_EN
    .stall               (stall),
`endif
    .start               (start),
    .ready               (ready),
    .vl                  (vl),
    .vm                  (vm),
    .mask_bits           (mask_bits),
    .alu_signal_in       (alu_signal_in),
    .vec_operand_type_in (vec_operand_type_in),
    .opcode_in           (opcode_in),
    .alu_signal          (alu_signal),
    .vec_operand_type    (vec_operand_type),
    .opcode              (opcode),
    .lane_en             (lane_en),
    .elem_base           (elem_base),
    .lane_result         (lane_result),
    .wb_en               (wb_en),
    .wb_base             (wb_base),
    .wb_data             (wb_data),
    .done                (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Lane k of the group starting at element 'base' writes iff it is inside vl and unmasked.
  function automatic logic [1:0] exp_en(input int base, input int vle, input bit vmv,
                                        input logic [7:0] m);
    logic [1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      if (base + k < vle) r[k] = vmv | m[base + k];
    end
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic scramble_inputs();
    vl                  = 4'($urandom_range(0, 15));
    vm                  = 1'($urandom_range(0, 1));
    mask_bits           = 8'($urandom);
    alu_signal_in       = 3'($urandom);
    vec_operand_type_in = 2'($urandom);
    opcode_in           = 6'($urandom);
    lane_result         = rand64();
  endtask

  task automatic run_instr(input string name, input int vl_in, input bit vm_in,
                           input logic [7:0] mask_in, input bit busy_pulse,
                           input int stall_from, input int stall_len);
    int vle, n, s, c, done_cyc;
    logic [2:0]  a_op;
    logic [1:0]  o_ty;
    logic [5:0]  opc;
    logic [63:0] last_res;
    logic [2:0]  last_base;
    vle       = (vl_in > VSIZE) ? VSIZE : vl_in;
    n         = (vle + LANES - 1) / LANES;
    a_op      = 3'($urandom);
    o_ty      = 2'($urandom);
    opc       = 6'($urandom);
    done_cyc  = -1;
    last_base = '0;

    @(posedge clk); #1;
    start = 1'b1; vl = 4'(vl_in); vm = vm_in; mask_bits = mask_in;
    alu_signal_in = a_op; vec_operand_type_in = o_ty; opcode_in = opc;
    lane_result = rand64(); last_res = lane_result; stall = 1'b0;
    @(negedge clk);
    check({name, ".ready_idle"}, 64'(ready), 64'd1);

    s = 1;
    c = 1;
    while (s <= n + 1) begin
      @(posedge clk); #1;
      scramble_inputs();
      start = busy_pulse && (c == 2);
      stall = (STALL_ON != 0) && (c >= stall_from) && (c < stall_from + stall_len);
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = c;
      check({name, ".ready_busy"}, 64'(ready), 64'd0);
      check({name, ".wb_data"}, wb_data, last_res);
      if (s >= 2 && n > 0) check({name, ".wb_base"}, 64'(wb_base), 64'(last_base));
      if (s <= n) check({name, ".elem_base"}, 64'(elem_base), 64'((s - 1) * LANES));
      if (c == 1) begin
        check({name, ".alu_signal"}, 64'(alu_signal), 64'(a_op));
        check({name, ".operand_type"}, 64'(vec_operand_type), 64'(o_ty));
        check({name, ".opcode"}, 64'(opcode), 64'(opc));
      end
      if (stall) begin
        check({name, ".lane_en_stall"}, 64'(lane_en), 64'd0);
        check({name, ".wb_en_stall"}, 64'(wb_en), 64'd0);
        check({name, ".done_stall"}, 64'(done), 64'd0);
      end else begin
        check({name, ".lane_en"}, 64'(lane_en),
              64'((s <= n) ? exp_en((s - 1) * LANES, vle, vm_in, mask_in) : 2'b00));
        check({name, ".wb_en"}, 64'(wb_en),
              64'((s >= 2) ? exp_en((s - 2) * LANES, vle, vm_in, mask_in) : 2'b00));
        check({name, ".done"}, 64'(done), 64'(s == n + 1));
        last_res = lane_result;
        if (s <= n) last_base = 3'((s - 1) * LANES);
        s++;
      end
      c++;
    end

    @(posedge clk); #1;
    start = 1'b0; stall = 1'b0; lane_result = rand64();
    @(negedge clk);
    check({name, ".ready_after"}, 64'(ready), 64'd1);
    check({name, ".done_after"}, 64'(done), 64'd0);
    check({name, ".wb_en_after"}, 64'(wb_en), 64'd0);
    check({name, ".lane_en_after"}, 64'(lane_en), 64'd0);
    check({name, ".opcode_held"}, 64'(opcode), 64'(opc));
    check({name, ".done_latency"}, 64'(done_cyc), 64'(n + 1 + stall_len));
    $display("instr %s vl=%0d vm=%0d mask=%02h busy_start=%0d stall=%0d@%0d done_cycle=%0d",
             name, vl_in, vm_in, mask_in, busy_pulse, stall_len, stall_from, done_cyc);
  endtask

  task automatic reset_abort();
    @(posedge clk); #1;
    start = 1'b1; vl = 4'd12; vm = 1'b1; mask_bits = 8'h00; lane_result = rand64();
    @(posedge clk); #1;
    scramble_inputs(); start = 1'b0;
    @(negedge clk);
    check("abort.lane_en_c1", 64'(lane_en), 64'h3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort.elem_base_c2", 64'(elem_base), 64'd2);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort.ready", 64'(ready), 64'd1);
    check("abort.lane_en", 64'(lane_en), 64'd0);
    check("abort.wb_en", 64'(wb_en), 64'd0);
    check("abort.wb_data", wb_data, 64'd0);
    check("abort.elem_base", 64'(elem_base), 64'd0);
    check("abort.opcode", 64'(opcode), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      lane_result = rand64();
      @(negedge clk);
      check("abort.no_done", 64'(done), 64'd0);
      check("abort.no_wb", 64'(wb_en), 64'd0);
    end
    $display("instr abort vl=12 reset in second ISSUE cycle");
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; start = 1'b0; vl = '0; vm = 1'b1; mask_bits = '0;
    alu_signal_in = '0; vec_operand_type_in = '0; opcode_in = '0; lane_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.ready", 64'(ready), 64'd1);
    check("reset.done", 64'(done), 64'd0);
    check("reset.lane_en", 64'(lane_en), 64'd0);
    check("reset.wb_en", 64'(wb_en), 64'd0);
    check("reset.elem_base", 64'(elem_base), 64'd0);
    check("reset.wb_base", 64'(wb_base), 64'd0);
    check("reset.wb_data", wb_data, 64'd0);
    check("reset.alu_signal", 64'(alu_signal), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr("full8", 8, 1'b1, 8'h00, 1'b0, 0, 0);
    run_instr("tail5", 5, 1'b1, 8'h00, 1'b0, 0, 0);
    run_instr("mask8", 8, 1'b0, 8'b1010_0101, 1'b0, 0, 0);
    run_instr("vl0", 0, 1'b1, 8'hFF, 1'b0, 0, 0);
    run_instr("clamp12", 12, 1'b1, 8'h00, 1'b1, 0, 0);
    run_instr("stall4", 4, 1'b1, 8'h00, 1'b0, 2, 3 * STALL_ON);
    for (int i = 0; i < 16; i++) begin
      run_instr("rand", $urandom_range(0, 12), 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(1, 3),
                STALL_ON * $urandom_range(0, 3));
    end
    reset_abort();
    run_instr("post_abort", 7, 1'b0, 8'($urandom), 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
